// File: rtl/melody_pkg.sv
// melody_pkg: state encoding, note codes, ROM word layout and
// speaker divider table shared by the melody sequencer files.
package melody_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_GAP   = 2'd2,
    ST_PAUSE = 2'd3
  } seq_state_e;

  localparam logic [2:0] NOTE_REST = 3'd0;
  localparam logic [2:0] NOTE_DO   = 3'd1;
  localparam logic [2:0] NOTE_RE   = 3'd2;
  localparam logic [2:0] NOTE_MI   = 3'd3;
  localparam logic [2:0] NOTE_FA   = 3'd4;
  localparam logic [2:0] NOTE_SO   = 3'd5;
  localparam logic [2:0] NOTE_LA   = 3'd6;
  localparam logic [2:0] NOTE_SI   = 3'd7;

  localparam int NOTE_DIV_W = 22;

  localparam logic [21:0] DIV_DO = 22'd190840;
  localparam logic [21:0] DIV_RE = 22'd170068;
  localparam logic [21:0] DIV_MI = 22'd151515;
  localparam logic [21:0] DIV_FA = 22'd143266;
  localparam logic [21:0] DIV_SO = 22'd127551;
  localparam logic [21:0] DIV_LA = 22'd113636;
  localparam logic [21:0] DIV_SI = 22'd101215;

  typedef struct packed {
    logic [2:0] code;
    logic [1:0] rsvd;
    logic [2:0] dur;
  } rom_entry_t;

  function automatic rom_entry_t rom_word(
    input logic [2:0] code,
    input logic [2:0] dur
  );
    rom_entry_t w;
    w.code = code;
    w.rsvd = 2'b00;
    w.dur  = dur;
    return w;
  endfunction

  function automatic logic [NOTE_DIV_W-1:0] note_div_of(
    input logic [2:0] code
  );
    logic [NOTE_DIV_W-1:0] d;
    case (code)
      NOTE_DO: d = DIV_DO;
      NOTE_RE: d = DIV_RE;
      NOTE_MI: d = DIV_MI;
      NOTE_FA: d = DIV_FA;
      NOTE_SO: d = DIV_SO;
      NOTE_LA: d = DIV_LA;
      NOTE_SI: d = DIV_SI;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// melody_rom: fixed melody table, combinational lookup by index.
// Entries past the stored tune read back as a one-beat rest.
module melody_rom
  import melody_pkg::*;
#(
  parameter int IW = 4
) (
  input  logic [IW-1:0] index,
  output rom_entry_t    entry
);

  // table lookup
  always_comb begin
    entry = rom_word(NOTE_REST, 3'd1);
    case (32'(index))
      0:  entry = rom_word(NOTE_DO, 3'd1);
      1:  entry = rom_word(NOTE_RE, 3'd1);
      2:  entry = rom_word(NOTE_MI, 3'd1);
      3:  entry = rom_word(NOTE_DO, 3'd1);
      4:  entry = rom_word(NOTE_DO, 3'd1);
      5:  entry = rom_word(NOTE_RE, 3'd1);
      6:  entry = rom_word(NOTE_MI, 3'd1);
      7:  entry = rom_word(NOTE_DO, 3'd1);
      8:  entry = rom_word(NOTE_MI, 3'd1);
      9:  entry = rom_word(NOTE_FA, 3'd1);
      10: entry = rom_word(NOTE_SO, 3'd2);
      11: entry = rom_word(NOTE_REST, 3'd1);
      12: entry = rom_word(NOTE_MI, 3'd1);
      13: entry = rom_word(NOTE_FA, 3'd1);
      14: entry = rom_word(NOTE_SO, 3'd2);
      15: entry = rom_word(NOTE_REST, 3'd1);
      default: entry = rom_word(NOTE_REST, 3'd1);
    endcase
  end

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays the ROM melody with gaps, live keys override.
// Define MELODY_LOOP_EN to loop forever instead of stopping with done.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int SEQ_LEN    = 16,
  parameter int GAP_CYCLES = 1_000_000,
  parameter int DIV_W      = 22
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       beat_tick,
  input  logic                       play_pulse,
  input  logic                       stop_pulse,
  input  logic                       manual_valid,
  input  logic [DIV_W-1:0]           manual_note_div,
  output logic [DIV_W-1:0]           note_div,
  output logic                       note_valid,
  output logic [$clog2(SEQ_LEN)-1:0] seq_index,
  output logic [1:0]                 seq_state,
  output logic                       done
);

  localparam int IW = $clog2(SEQ_LEN);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [IW-1:0] LAST   = IW'(SEQ_LEN - 1);
  localparam logic [GW-1:0] GAP_LD = GW'(GAP_CYCLES - 1);

  seq_state_e state, state_n;
  logic [IW-1:0] index, index_n, ld_index;
  logic [2:0] dur, dur_n, code, code_n;
  logic [GW-1:0] gap, gap_n;
  logic ret, ret_n;
  logic done_n, load, tick, valid_n;
  logic [DIV_W-1:0] div_n;
  rom_entry_t entry;
  logic unused_rsvd;

  // next ROM slot to enter PLAY on: 0 from IDLE or after the last note
  assign ld_index = (state == ST_GAP && index != LAST)
                  ? index + 1'b1 : '0;

  melody_rom #(.IW(IW)) u_rom (
    .index (ld_index),
    .entry (entry)
  );

  assign unused_rsvd = ^entry.rsvd;
  assign seq_index   = index;
  assign seq_state   = state;

  // state register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      index      <= '0;
      dur        <= '0;
      gap        <= '0;
      code       <= NOTE_REST;
      ret        <= 1'b0;
      done       <= 1'b0;
      note_div   <= '0;
      note_valid <= 1'b0;
    end else begin
      state      <= state_n;
      index      <= index_n;
      dur        <= dur_n;
      gap        <= gap_n;
      code       <= code_n;
      ret        <= ret_n;
      done       <= done_n;
      note_div   <= div_n;
      note_valid <= valid_n;
    end
  end

  // next state, counters and the output value they imply
  always_comb begin
    state_n = state;
    index_n = index;
    dur_n   = dur;
    gap_n   = gap;
    code_n  = code;
    ret_n   = ret;
    done_n  = 1'b0;
    load    = 1'b0;
    div_n   = '0;
    valid_n = 1'b0;
    tick    = beat_tick & ~manual_valid;
    if (stop_pulse) begin
      state_n = ST_IDLE;
      index_n = '0;
      dur_n   = '0;
      gap_n   = '0;
      code_n  = NOTE_REST;
      ret_n   = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (play_pulse) begin
            state_n = ST_PLAY;
            load    = 1'b1;
          end
        end
        ST_PLAY: begin
          if (play_pulse) begin
            state_n = ST_PAUSE;
            ret_n   = 1'b0;
          end else if (tick) begin
            if (dur == 3'd1) begin
              state_n = ST_GAP;
              gap_n   = GAP_LD;
            end else begin
              dur_n = dur - 3'd1;
            end
          end
        end
        ST_GAP: begin
          if (play_pulse) begin
            state_n = ST_PAUSE;
            ret_n   = 1'b1;
          end else if (!manual_valid) begin
            if (gap != '0) begin
              gap_n = gap - 1'b1;
            end else if (index != LAST) begin
              state_n = ST_PLAY;
              load    = 1'b1;
            end else begin
`ifdef MELODY_LOOP_EN
              state_n = ST_PLAY;
              load    = 1'b1;
`else
              state_n = ST_IDLE;
              index_n = '0;
              dur_n   = '0;
              code_n  = NOTE_REST;
              done_n  = 1'b1;
`endif
            end
          end
        end
        ST_PAUSE: begin
          if (play_pulse) begin
            state_n = ret ? ST_GAP : ST_PLAY;
          end
        end
        default: state_n = ST_IDLE;
      endcase
      if (load) begin
        index_n = ld_index;
        code_n  = entry.code;
        dur_n   = (entry.dur == 3'd0) ? 3'd1 : entry.dur;
      end
    end
    if (manual_valid) begin
      div_n   = manual_note_div;
      valid_n = 1'b1;
    end else if (state_n == ST_PLAY && code_n != NOTE_REST) begin
      div_n   = DIV_W'(note_div_of(code_n));
      valid_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed checks of play, gap, pause, manual
// override, stop and reset; end-of-melody follows MELODY_LOOP_EN.
module tb_melody_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        beat_tick = 1'b0;
  logic        play_pulse = 1'b0;
  logic        stop_pulse = 1'b0;
  logic        manual_valid = 1'b0;
  logic [21:0] manual_note_div = '0;
  logic [21:0] note_div;
  logic        note_valid;
  logic [3:0]  seq_index;
  logic [1:0]  seq_state;
  logic        done;

  int n_chk = 0;
  int n_pass = 0;

  melody_sequencer #(
    .SEQ_LEN    (16),
    .GAP_CYCLES (4),
    .DIV_W      (22)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .beat_tick       (beat_tick),
    .play_pulse      (play_pulse),
    .stop_pulse      (stop_pulse),
    .manual_valid    (manual_valid),
    .manual_note_div (manual_note_div),
    .note_div        (note_div),
    .note_valid      (note_valid),
    .seq_index       (seq_index),
    .seq_state       (seq_state),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic outs(input string tag, input int st,
                      input int idx, input int div, input int vld);
    chk({tag, ".st"},  32'(seq_state),  32'(st));
    chk({tag, ".idx"}, 32'(seq_index),  32'(idx));
    chk({tag, ".div"}, 32'(note_div),   32'(div));
    chk({tag, ".vld"}, 32'(note_valid), 32'(vld));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic play();
    play_pulse = 1'b1;
    cyc(1);
    play_pulse = 1'b0;
  endtask

  task automatic beat();
    cyc(9);
    beat_tick = 1'b1;
    cyc(1);
    beat_tick = 1'b0;
  endtask

  task automatic next_note();
    beat();
    cyc(4);
  endtask

  initial begin
    #2 rst = 1'b0;
    cyc(2);
    outs("rst", 0, 0, 0, 0);
    chk("rst.done", 32'(done), 0);
    rst = 1'b1;
    cyc(1);

    play();
    outs("start", 1, 0, 190840, 1);
    beat();
    for (int i = 0; i < 4; i++) begin
      outs($sformatf("gap%0d", i), 2, 0, 0, 0);
      cyc(1);
    end
    outs("n1", 1, 1, 170068, 1);
    next_note();
    outs("n2", 1, 2, 151515, 1);
    next_note();
    outs("n3", 1, 3, 190840, 1);

    play();
    outs("pause3", 3, 3, 0, 0);
    repeat (5) beat();
    outs("held3", 3, 3, 0, 0);
    play();
    outs("resume3", 1, 3, 190840, 1);
    beat();
    outs("gap3", 2, 3, 0, 0);
    play();
    outs("gpause", 3, 3, 0, 0);
    repeat (5) beat();
    play();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("gres%0d", i), 32'(seq_state), 2);
      cyc(1);
    end
    outs("n4", 1, 4, 190840, 1);

    repeat (6) next_note();
    outs("n10", 1, 10, 127551, 1);
    beat();
    outs("n10b1", 1, 10, 127551, 1);
    play();
    repeat (2) beat();
    play();
    outs("n10res", 1, 10, 127551, 1);
    beat();
    outs("n10end", 2, 10, 0, 0);
    cyc(4);
    outs("rest11", 1, 11, 0, 0);

    beat_tick = 1'b1;
    play_pulse = 1'b1;
    cyc(1);
    beat_tick = 1'b0;
    play_pulse = 1'b0;
    outs("tickpl", 3, 11, 0, 0);
    play();
    outs("tkres", 1, 11, 0, 0);
    beat();
    chk("tkgap", 32'(seq_state), 2);
    cyc(4);
    outs("n12", 1, 12, 151515, 1);
    repeat (2) next_note();
    outs("n14", 1, 14, 127551, 1);
    beat();
    outs("n14b1", 1, 14, 127551, 1);
    beat();
    cyc(4);
    outs("n15", 1, 15, 0, 0);
    beat();
    cyc(3);
    chk("lastgap", 32'(seq_state), 2);
    chk("lastgap.done", 32'(done), 0);
    cyc(1);
`ifdef MELODY_LOOP_EN
    outs("wrap", 1, 0, 190840, 1);
    chk("wrap.done", 32'(done), 0);
    cyc(1);
    chk("wrap.done2", 32'(done), 0);
`else
    outs("end", 0, 0, 0, 0);
    chk("end.done", 32'(done), 1);
    cyc(1);
    chk("end.done2", 32'(done), 0);
    chk("end.st2", 32'(seq_state), 0);
`endif

    stop_pulse = 1'b1;
    cyc(1);
    stop_pulse = 1'b0;
    outs("stop", 0, 0, 0, 0);
    play();
    manual_valid = 1'b1;
    manual_note_div = 22'd151515;
    cyc(1);
    outs("man", 1, 0, 151515, 1);
    repeat (3) beat();
    outs("manbeat", 1, 0, 151515, 1);
    manual_valid = 1'b0;
    cyc(1);
    outs("manrel", 1, 0, 190840, 1);

    play_pulse = 1'b1;
    stop_pulse = 1'b1;
    cyc(1);
    play_pulse = 1'b0;
    stop_pulse = 1'b0;
    outs("stopwin", 0, 0, 0, 0);

    play();
    next_note();
    beat();
    cyc(1);
    outs("pregap", 2, 1, 0, 0);
    #2 rst = 1'b0;
    #1;
    outs("arst", 0, 0, 0, 0);
    chk("arst.done", 32'(done), 0);
    cyc(1);
    rst = 1'b1;
    cyc(2);
    outs("post", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
